// File: rtl/general_register_pkg.sv
// Shared types and helpers for the general register file arbiter:
// operand-width encoding, register indices, arbiter states and byte-lane decode.
package general_register_pkg;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10
    } reg_width_t;

    localparam int NUM_REGS = 8;

    localparam logic [2:0] EAX = 3'd0;
    localparam logic [2:0] ECX = 3'd1;
    localparam logic [2:0] EDX = 3'd2;
    localparam logic [2:0] EBX = 3'd3;
    localparam logic [2:0] ESP = 3'd4;
    localparam logic [2:0] EBP = 3'd5;
    localparam logic [2:0] ESI = 3'd6;
    localparam logic [2:0] EDI = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_t;

    // Byte-register encodings 4-7 (AH..BH) alias the second byte of EAX..EBX.
    function automatic logic [2:0] phys_index(input logic [1:0] width, input logic [2:0] sel);
        return (width == W8) ? {1'b0, sel[1:0]} : sel;
    endfunction

    // Reserved width 2'b11 falls through to the full 32-bit mask.
    function automatic logic [31:0] lane_mask(input logic [1:0] width, input logic [2:0] sel);
        if (width == W8) begin
            return sel[2] ? 32'h0000_FF00 : 32'h0000_00FF;
        end
        if (width == W16) begin
            return 32'h0000_FFFF;
        end
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [4:0] lane_shift(input logic [1:0] width, input logic [2:0] sel);
        return (width == W8 && sel[2]) ? 5'd8 : 5'd0;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin grant with lock hold. Grant is combinational from req; the pointer
// remembers the last granted requester so the next one in order gets priority.
module round_robin_arbiter
    import general_register_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  lock,
    input  logic [N_REQ-1:0]  ack,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output arb_state_t        state
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [N_REQ-1:0] eligible;
    logic             owner_locked;
    arb_state_t       next_state;

    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = ptr;
        cand         = '0;
        eligible     = req & ~ack;
        next_state   = ST_IDLE;
        owner_locked = (state == ST_LOCKED) && lock[ptr];

        // A lock owner streams back-to-back accesses, so its own ack does not block it.
        if (owner_locked) begin
            grant_valid = req[ptr];
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % N_REQ);
                if (!grant_valid && eligible[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end

        if (grant_valid) begin
            next_state = lock[grant_idx] ? ST_LOCKED : ST_ACCESS;
        end else if (owner_locked) begin
            next_state = ST_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= IDX_W'(N_REQ - 1);
        end else begin
            state <= next_state;
            if (grant_valid) begin
                ptr <= grant_idx;
            end
        end
    end

endmodule

// File: rtl/general_register_file_arbiter.sv
// Eight 32-bit x86-style general registers shared by N_REQ requesters. One access
// completes per clock; ack and rdata appear the cycle after the grant.
module general_register_file_arbiter
    import general_register_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ-1:0][2:0]  register,
    input  logic [N_REQ-1:0][1:0]  bit_width,
    input  logic [N_REQ-1:0][31:0] wdata,
    output logic [N_REQ-1:0]       ack,
    output logic [31:0]            rdata,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [31:0]      regs [NUM_REGS];
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    arb_state_t       arb_state;
    logic [2:0]       sel_index;
    logic [31:0]      sel_mask;
    logic [4:0]       sel_shift;
    logic [31:0]      read_value;
    logic [31:0]      write_value;

    round_robin_arbiter #(.N_REQ(N_REQ)) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .state       (arb_state)
    );

    assign busy = (arb_state == ST_LOCKED);

    always_comb begin
        sel_index   = phys_index(bit_width[grant_idx], register[grant_idx]);
        sel_mask    = lane_mask(bit_width[grant_idx], register[grant_idx]);
        sel_shift   = lane_shift(bit_width[grant_idx], register[grant_idx]);
        read_value  = (regs[sel_index] & sel_mask) >> sel_shift;
        write_value = (regs[sel_index] & ~sel_mask) | ((wdata[grant_idx] << sel_shift) & sel_mask);
    end

    // rdata carries the field as it stood before this edge, so a write reports the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            ack   <= '0;
            rdata <= '0;
        end else begin
            ack   <= '0;
            rdata <= '0;
            if (grant_valid) begin
                ack[grant_idx] <= 1'b1;
                rdata          <= read_value;
                if (we[grant_idx]) begin
                    regs[sel_index] <= write_value;
                end
            end
        end
    end

endmodule

// File: doc/general_register_file_arbiter.md
GENERAL_REGISTER_FILE_ARBITER -- requirements
Module: general_register_file_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, meaning number of requesters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  N_REQ  per-requester access request, held until ack.
REQ-005 SHALL have port lock  input  N_REQ  per-requester hold of grant across consecutive accesses.
REQ-006 SHALL have port we  input  N_REQ  per-requester write enable (0 = read).
REQ-007 SHALL have port register  input  N_REQ x 3  per-requester reg field encoding.
REQ-008 SHALL have port bit_width  input  N_REQ x 2  per-requester operand width (reg_width_t).
REQ-009 SHALL have port wdata  input  N_REQ x 32  per-requester write data, right-aligned.
REQ-010 SHALL have port ack  output  N_REQ  one-cycle completion pulse, one-hot or zero.
REQ-011 SHALL have port rdata  output  32  read result, right-aligned and zero-extended; valid while any ack bit is high.
REQ-012 SHALL have port busy  output  1  high while a lock is held.

Function
REQ-013 SHALL contain eight 32-bit general registers, EAX..EDI in indices 0..7.
REQ-014 SHALL decode width 8 as: register 0-3 selects bits 7:0 of EAX/ECX/EDX/EBX (AL,CL,DL,BL); register 4-7 selects bits 15:8 of EAX/ECX/EDX/EBX (AH,CH,DH,BH).
REQ-015 SHALL decode width 16 as bits 15:0 of register index; width 32 as full register.
REQ-016 SHALL treat reserved width encoding 2'b11 as width 32.
REQ-017 SHALL, on write, update only the selected byte lanes; all other bits of all registers unchanged.
REQ-018 SHALL grant at most one requester per cycle; grant is computed combinationally from req in cycle N.
REQ-019 SHALL complete the granted access at the clock edge ending cycle N, and assert ack and rdata during cycle N+1 (latency 1).
REQ-020 SHALL return, for a read, register contents as of the end of cycle N, i.e. before any write granted in N+1.
REQ-021 SHALL suppress re-grant of a requester in the cycle its ack is high; requester deasserts req or presents a new request after ack.
REQ-022 SHALL arbitrate round-robin: after a grant to requester i, priority order is i+1, i+2, ... wrapping modulo N_REQ.
REQ-023 SHALL, when granted requester has lock high, enter state LOCKED and grant only that requester until its lock drops; pointer does not advance in LOCKED.
REQ-024 SHALL use states IDLE (no access pending), ACCESS (grant issued, ack next cycle), LOCKED; IDLE->ACCESS on any req; ACCESS->LOCKED if lock of owner high, else ACCESS/IDLE per req; LOCKED->IDLE when owner lock low and no req.
REQ-025 SHALL ignore lock from requesters not holding the grant.
REQ-026 SHALL drive rdata to 0 when no ack is high.

Reset
REQ-027 SHALL, on reset, clear all eight registers to 0, ack to 0, rdata to 0, busy to 0, state to IDLE, round-robin pointer to requester 0 highest priority.
REQ-028 SHALL abort any in-flight access on reset: no ack issued, no write committed in the reset cycle.

Structure
REQ-029 SHALL take reg_width_t (W8=2'b00, W16=2'b01, W32=2'b10) and register index constants from shared package general_register_pkg.
REQ-030 SHALL implement the round-robin grant with lock hold in one sub-module, round_robin_arbiter.

Verification
REQ-031 SHALL cover: write W32 reg0 = 32'h12345678 then W8 reg4 (AH) = 8'hAB -> read W32 reg0 returns 32'h1234AB78.
REQ-032 SHALL cover: req=3'b111 all reads, continuously reasserted -> ack sequence 001,010,100,001 on consecutive cycles.
REQ-033 SHALL cover: requester 1 lock=1 with req held 3 accesses, req[0] and req[2] high -> only ack[1] for 3 cycles, busy=1, then round-robin resumes at requester 2.
REQ-034 SHALL cover: read W16 reg6 (SI) after write W32 reg6 = 32'hDEADBEEF -> rdata 32'h0000BEEF.
REQ-035 SHALL cover: reset asserted in the cycle a write of 32'hFFFFFFFF to reg3 is granted -> no ack, reg3 reads 0 after reset.
